// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, imem address, IF/ID pipeline register with stall/flush/redirect.
// Latency: imem_addr follows pc_f combinationally; the fetched word reaches ins_d one cycle later.
// Backpressure: stall_f freezes both PC and IF/ID; redirect (pc_src) overrides stall and squashes IF/ID.
module fetch_stage #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] NOP      = WIDTH'(32'h0000_0013)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_f,
  input  logic             flush_d,
  input  logic             pc_src,
  input  logic [WIDTH-1:0] pc_target,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] ins_d,
  output logic [WIDTH-1:0] pc_d,
  output logic [WIDTH-1:0] pc_plus4_d,
  output logic             valid_d,
  output logic             misalign_err,
  output logic [31:0]      fetch_count
);

  localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);

  logic [WIDTH-1:0] pc_f_q, pc_f_d;
  logic [WIDTH-1:0] ins_q, ins_d_nxt;
  logic [WIDTH-1:0] pc_d_q, pc_d_d;
  logic [WIDTH-1:0] pc_plus4_q, pc_plus4_d_nxt;
  logic             valid_q, valid_d_nxt;
  logic             misalign_q, misalign_d;
  logic [31:0]      count_q, count_d;

  logic             squash;
  logic [WIDTH-1:0] pc_f_plus4;

  assign squash     = flush_d | pc_src;
  assign pc_f_plus4 = pc_f_q + FOUR;

  // Next PC: redirect beats stall so a branch resolved during a stall is not lost.
  always_comb begin
    pc_f_d = pc_f_plus4;
    if (pc_src) begin
      pc_f_d = {pc_target[WIDTH-1:2], 2'b00};
    end else if (stall_f) begin
      pc_f_d = pc_f_q;
    end
  end

  // IF/ID register next state: squash > stall > load; misalign flag is sticky.
  always_comb begin
    ins_d_nxt      = ins_q;
    pc_d_d         = pc_d_q;
    pc_plus4_d_nxt = pc_plus4_q;
    valid_d_nxt    = valid_q;
    count_d        = count_q;
    misalign_d     = misalign_q | (pc_src & (pc_target[1:0] != 2'b00));
    if (squash) begin
      ins_d_nxt      = NOP;
      pc_d_d         = '0;
      pc_plus4_d_nxt = '0;
      valid_d_nxt    = 1'b0;
    end else if (!stall_f) begin
      ins_d_nxt      = imem_rdata;
      pc_d_d         = pc_f_q;
      pc_plus4_d_nxt = pc_f_plus4;
      valid_d_nxt    = 1'b1;
      // Delivered-instruction counter saturates rather than wrapping.
      if (count_q != 32'hFFFF_FFFF) begin
        count_d = count_q + 32'd1;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_f_q     <= RESET_PC;
      ins_q      <= NOP;
      pc_d_q     <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      count_q    <= '0;
    end else begin
      pc_f_q     <= pc_f_d;
      ins_q      <= ins_d_nxt;
      pc_d_q     <= pc_d_d;
      pc_plus4_q <= pc_plus4_d_nxt;
      valid_q    <= valid_d_nxt;
      misalign_q <= misalign_d;
      count_q    <= count_d;
    end
  end

  assign imem_addr    = pc_f_q;
  assign ins_d        = ins_q;
  assign pc_d         = pc_d_q;
  assign pc_plus4_d   = pc_plus4_q;
  assign valid_d      = valid_q;
  assign misalign_err = misalign_q;
  assign fetch_count  = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random stall/flush/redirect traffic.
// A behavioural model tracks fetch PC, the instruction handed to decode and the counters.
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_f, flush_d, pc_src;
  logic [31:0] pc_target;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] ins_d, pc_d, pc_plus4_d;
  logic        valid_d, misalign_err;
  logic [31:0] fetch_count;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_ins, m_pcd, m_pc4;
  logic        m_vld, m_mis;
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall_f(stall_f), .flush_d(flush_d), .pc_src(pc_src),
    .pc_target(pc_target), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .ins_d(ins_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d),
    .misalign_err(misalign_err), .fetch_count(fetch_count)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 | a;
  endfunction

  // Instruction memory: combinational read of the address the DUT presents.
  always_comb imem_rdata = mem_word(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string where);
    chk({where, ":imem_addr"},    imem_addr,           m_pc);
    chk({where, ":ins_d"},        ins_d,               m_ins);
    chk({where, ":pc_d"},         pc_d,                m_pcd);
    chk({where, ":pc_plus4_d"},   pc_plus4_d,          m_pc4);
    chk({where, ":valid_d"},      {31'd0, valid_d},    {31'd0, m_vld});
    chk({where, ":misalign_err"}, {31'd0, misalign_err}, {31'd0, m_mis});
    chk({where, ":fetch_count"},  fetch_count,         m_cnt);
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_ins = 32'h0000_0013; m_pcd = 0; m_pc4 = 0;
    m_vld = 0; m_mis = 0; m_cnt = 0;
  endtask

  // One clock with the given controls; model advances by the fetch rules, then everything is checked.
  task automatic cyc(input logic st, input logic fl, input logic src, input logic [31:0] tgt,
                     input string where);
    logic [31:0] fetched_pc;
    stall_f = st; flush_d = fl; pc_src = src; pc_target = tgt;
    @(posedge clk);
    fetched_pc = m_pc;
    if (src && tgt[1:0] != 2'b00) m_mis = 1'b1;
    if (fl || src) begin
      m_ins = 32'h0000_0013; m_pcd = 0; m_pc4 = 0; m_vld = 0;
    end else if (!st) begin
      m_ins = mem_word(fetched_pc); m_pcd = fetched_pc; m_pc4 = fetched_pc + 32'd4; m_vld = 1;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end
    if (src)      m_pc = tgt & 32'hFFFF_FFFC;
    else if (!st) m_pc = fetched_pc + 32'd4;
    #1;
    chk_all(where);
  endtask

  initial begin
    logic [31:0] t;
    logic st, fl, src;
    rst = 1'b1; stall_f = 0; flush_d = 0; pc_src = 0; pc_target = 0;
    model_reset();
    #12;
    chk_all("reset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_all("post_reset");

    // Free run: pc_d 0,4,8,C
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, "freerun");
    chk("freerun:count4", fetch_count, 32'd4);
    chk("freerun:pc_d_C", pc_d, 32'h0000_000C);

    // Stall for 2 cycles, then resume
    cyc(1, 0, 0, 0, "stall1");
    cyc(1, 0, 0, 0, "stall2");
    chk("stall:count_held", fetch_count, 32'd4);
    cyc(0, 0, 0, 0, "resume1");
    cyc(0, 0, 0, 0, "resume2");

    // Redirect to 0x40: one bubble then target instruction
    cyc(0, 0, 1, 32'h40, "redir");
    chk("redir:ins_nop", ins_d, 32'h0000_0013);
    cyc(0, 0, 0, 0, "redir_next");
    chk("redir:pc_d_40", pc_d, 32'h40);
    cyc(0, 0, 0, 0, "redir_next2");

    // Redirect during stall wins
    cyc(1, 0, 1, 32'h80, "redir_stall");
    chk("redir_stall:pc_80", imem_addr, 32'h80);
    cyc(0, 0, 0, 0, "after_rs");

    // Stall with flush: PC holds, IF/ID squashed
    cyc(1, 1, 0, 0, "stall_flush");
    cyc(0, 1, 0, 0, "flush_only");
    cyc(0, 0, 0, 0, "after_flush");

    // Misaligned redirect: sticky flag
    cyc(0, 0, 1, 32'h0000_0102, "misalign");
    chk("misalign:pc_100", imem_addr, 32'h100);
    for (int i = 0; i < 10; i++) cyc(i[0], 0, 0, 0, "mis_hold");
    chk("misalign:sticky", {31'd0, misalign_err}, 32'd1);

    // Address wrap
    cyc(0, 0, 1, 32'hFFFF_FFFC, "wrap_redir");
    cyc(0, 0, 0, 0, "wrap1");
    chk("wrap:pc_d", pc_d, 32'hFFFF_FFFC);
    chk("wrap:pc4_zero", pc_plus4_d, 32'h0);
    cyc(0, 0, 0, 0, "wrap2");
    chk("wrap:pc_d_zero", pc_d, 32'h0);

    // Async reset mid-stall, checked before the next edge
    stall_f = 1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    chk_all("async_rst");
    @(negedge clk);
    chk_all("rst_held");
    rst = 1'b0; stall_f = 0;
    #1;

    // Random traffic; first half aligned targets only, then misaligned allowed
    for (int i = 0; i < 400; i++) begin
      st  = ($urandom_range(0, 3) == 0);
      fl  = ($urandom_range(0, 6) == 0);
      src = ($urandom_range(0, 6) == 0);
      t   = $urandom;
      if (i < 200 || $urandom_range(0, 4) != 0) t = t & 32'hFFFF_FFFC;
      cyc(st, fl, src, t, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
